pcie_msix_irq_sched: RTL

- Shares the PCIe hard IP's single MSI-X request interface (cfg_interrupt_msix_*) between PORTS interrupt requesters using round-robin arbitration.
- For each granted request, reads the vector's entry from the user-side MSI-X table RAM and honours the function-level and per-vector mask bits.
- Drives the hard IP request and retries on fail.
- Sits in fpga_core between the DMA/queue logic and the PCIe IP.

---
 rtl/pcie_msix_irq_sched.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/pcie_msix_irq_sched.sv
// pcie_msix_irq_sched: round-robin sharing of the PCIe hard IP MSI-X request
// port between PORTS requesters, with MSI-X table lookup, mask handling and
// retry on fail/timeout.
// Optional build macro: PCIE_MSIX_SCHED_STATS_EN (sent/fail/masked counters).
module pcie_msix_irq_sched #(
  parameter int unsigned PORTS           = 4,
  parameter int unsigned IRQ_INDEX_WIDTH = 11,
  parameter int unsigned ACK_TIMEOUT     = 1024
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [PORTS*IRQ_INDEX_WIDTH-1:0] s_irq_index,
  input  logic [PORTS-1:0]                 s_irq_valid,
  output logic [PORTS-1:0]                 s_irq_ready,
  output logic                             tbl_rd_en,
  output logic [IRQ_INDEX_WIDTH-1:0]       tbl_rd_addr,
  input  logic [127:0]                     tbl_rd_data,
  input  logic [3:0]                       cfg_interrupt_msix_enable,
  input  logic [3:0]                       cfg_interrupt_msix_mask,
  output logic [63:0]                      cfg_interrupt_msix_address,
  output logic [31:0]                      cfg_interrupt_msix_data,
  output logic                             cfg_interrupt_msix_int,
  input  logic                             cfg_interrupt_msix_sent,
  input  logic                             cfg_interrupt_msix_fail,
  output logic [7:0]                       cfg_interrupt_msi_function_number,
  output logic                             irq_drop,
  output logic                             busy,
  output logic [31:0]                      stat_sent,
  output logic [31:0]                      stat_fail,
  output logic [31:0]                      stat_masked
);

  localparam int unsigned PTR_W  = (PORTS > 1) ? $clog2(PORTS) : 1;
  localparam int unsigned WDOG_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE, ST_TBL_WAIT, ST_CHECK, ST_ISSUE, ST_WAIT_ACK
  } state_t;

  typedef struct packed {
    logic        vmask;
    logic [31:0] data;
    logic [63:0] addr;
  } entry_t;

  state_t              state, state_n;
  logic [PTR_W-1:0]    ptr, grant, cand, arb_port;
  logic                arb_hit;
  entry_t              entry;
  logic [63:0]         msg_addr;
  logic [31:0]         msg_data;
  logic [WDOG_W-1:0]   wdog;
  logic                ev_sent, ev_fail, ev_masked;

  // First valid requester at or after the round-robin pointer
  always_comb begin
    arb_hit  = 1'b0;
    arb_port = '0;
    cand     = '0;
    for (int unsigned i = 0; i < PORTS; i++) begin
      cand = PTR_W'((32'(ptr) + i) % PORTS);
      if (!arb_hit && s_irq_valid[cand]) begin
        arb_hit  = 1'b1;
        arb_port = cand;
      end
    end
  end

  // State register, grant/pointer, captured entry, message and watchdog
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      ptr      <= '0;
      grant    <= '0;
      entry    <= '0;
      msg_addr <= '0;
      msg_data <= '0;
      wdog     <= '0;
    end else begin
      state <= state_n;
      if (state == ST_IDLE && arb_hit) begin
        grant <= arb_port;
        ptr   <= PTR_W'((32'(arb_port) + 32'd1) % PORTS);
      end
      if (state == ST_TBL_WAIT) entry <= tbl_rd_data[96:0];
      if (state == ST_CHECK && state_n == ST_ISSUE) begin
        msg_addr <= entry.addr;
        msg_data <= entry.data;
      end
      if (state == ST_ISSUE) wdog <= '0;
      else if (state == ST_WAIT_ACK) wdog <= wdog + WDOG_W'(1);
    end
  end

  // Next-state and per-state strobes
  always_comb begin
    state_n     = state;
    tbl_rd_en   = 1'b0;
    tbl_rd_addr = '0;
    s_irq_ready = '0;
    irq_drop    = 1'b0;
    ev_sent     = 1'b0;
    ev_fail     = 1'b0;
    ev_masked   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (arb_hit) begin
          // Gated so nothing is strobed while reset is held
          tbl_rd_en   = rst_n;
          tbl_rd_addr = s_irq_index[32'(arb_port)*IRQ_INDEX_WIDTH +: IRQ_INDEX_WIDTH];
          state_n     = ST_TBL_WAIT;
        end
      end
      ST_TBL_WAIT: state_n = ST_CHECK;
      ST_CHECK: begin
        if (!cfg_interrupt_msix_enable[0]) begin
          s_irq_ready[grant] = 1'b1;
          irq_drop           = 1'b1;
          state_n            = ST_IDLE;
        end else if (cfg_interrupt_msix_mask[0] || entry.vmask) begin
          // Left pending at the requester; retried on its next turn
          ev_masked = 1'b1;
          state_n   = ST_IDLE;
        end else begin
          state_n = ST_ISSUE;
        end
      end
      ST_ISSUE: state_n = ST_WAIT_ACK;
      ST_WAIT_ACK: begin
        if (cfg_interrupt_msix_sent && !cfg_interrupt_msix_fail) begin
          s_irq_ready[grant] = 1'b1;
          ev_sent            = 1'b1;
          state_n            = ST_IDLE;
        end else if (cfg_interrupt_msix_fail || wdog == WDOG_W'(ACK_TIMEOUT - 1)) begin
          ev_fail = 1'b1;
          state_n = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  assign cfg_interrupt_msix_int            = (state == ST_ISSUE);
  assign cfg_interrupt_msix_address        = msg_addr;
  assign cfg_interrupt_msix_data           = msg_data;
  assign cfg_interrupt_msi_function_number = 8'd0;
  assign busy                              = (state != ST_IDLE);

  logic unused_bits;
  assign unused_bits = ^{tbl_rd_data[127:97], cfg_interrupt_msix_enable[3:1],
                         cfg_interrupt_msix_mask[3:1]};

`ifdef PCIE_MSIX_SCHED_STATS_EN
  logic [31:0] sent_cnt, fail_cnt, masked_cnt;

  // Event counters, wrapping at 2^32
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sent_cnt   <= '0;
      fail_cnt   <= '0;
      masked_cnt <= '0;
    end else begin
      if (ev_sent)   sent_cnt   <= sent_cnt + 32'd1;
      if (ev_fail)   fail_cnt   <= fail_cnt + 32'd1;
      if (ev_masked) masked_cnt <= masked_cnt + 32'd1;
    end
  end

  assign stat_sent   = sent_cnt;
  assign stat_fail   = fail_cnt;
  assign stat_masked = masked_cnt;
`else
  logic unused_ev;
  assign unused_ev   = ^{ev_sent, ev_fail, ev_masked};
  assign stat_sent   = '0;
  assign stat_fail   = '0;
  assign stat_masked = '0;
`endif

endmodule
